// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush/halt control for a 5-stage pipeline; HAZARD_PERF_CNT_EN builds the stall/flush counters
module pipeline_hazard_ctrl (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_useRs1,
  input  logic        id_useRs2,
  input  logic        ex_valid,
  input  logic [4:0]  ex_rd,
  input  logic        ex_isLoad,
  input  logic        ex_isBranch,
  input  logic        ex_bpr,
  input  logic        ex_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  input  logic        wb_valid,
  input  logic        wb_probablyHalt,
  output logic        latchn_ifid,
  output logic        latchn_idex,
  output logic        latchn_exmem,
  output logic        latchn_memwb,
  output logic        flush_ifid,
  output logic        flush_idex,
  output logic        pc_hold,
  output logic        redirect,
  output logic        halt,
  output logic        mem_timeout,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);
  typedef enum logic [1:0] {RUN, MEM_WAIT, HALTED} state_e;
  state_e     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic       timeout_q, timeout_d;
  logic       mem_stall, mispredict, load_use, halt_req;
  // hazard detection from the current stage contents
  always_comb begin
    mem_stall  = mem_req & ~mem_ready;
    mispredict = ex_valid & ex_isBranch & (ex_bpr != ex_taken);
    load_use   = ex_valid & ex_isLoad & (ex_rd != 5'd0) &
                 ((id_useRs1 & (id_rs1 == ex_rd)) | (id_useRs2 & (id_rs2 == ex_rd)));
    halt_req   = wb_valid & wb_probablyHalt & ~mem_stall;
  end
  // next state, memory wait counter and sticky timeout; HALTED only leaves via reset
  always_comb begin
    state_d   = state_q;
    wait_d    = 8'd0;
    timeout_d = timeout_q;
    if (state_q != HALTED) begin
      state_d   = halt_req ? HALTED : mem_stall ? MEM_WAIT : RUN;
      wait_d    = (state_q == MEM_WAIT && mem_stall) ? ((wait_q == 8'hFF) ? wait_q : wait_q + 8'd1) : 8'd0;
      timeout_d = timeout_q | (wait_d == 8'hFF);
    end
  end
  // state register
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q   <= RUN;
      wait_q    <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
    end
  end
  // prioritised pipeline control: reset > halted > memory wait > mispredict > load-use > normal
  always_comb begin
    latchn_ifid  = 1'b0;
    latchn_idex  = 1'b0;
    latchn_exmem = 1'b0;
    latchn_memwb = 1'b0;
    flush_ifid   = 1'b0;
    flush_idex   = 1'b0;
    pc_hold      = 1'b0;
    redirect     = 1'b0;
    if (!RSTn) begin
      {latchn_ifid, latchn_idex, latchn_exmem, latchn_memwb} = 4'hF;
      {flush_ifid, flush_idex} = 2'b11;
      pc_hold = 1'b1;
    end else if (state_q == HALTED || mem_stall) begin
      {latchn_ifid, latchn_idex, latchn_exmem, latchn_memwb} = 4'hF;
      pc_hold = 1'b1;
    end else if (mispredict) begin
      {flush_ifid, flush_idex} = 2'b11;
      redirect = 1'b1;
    end else if (load_use) begin
      latchn_ifid = 1'b1;
      flush_idex  = 1'b1;
      pc_hold     = 1'b1;
    end
  end
  assign halt        = (state_q == HALTED);
  assign mem_timeout = timeout_q;
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_q, stall_d, flush_q, flush_d;
  // saturating performance counters
  always_comb begin
    stall_d = (pc_hold && state_q != HALTED && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
    flush_d = (redirect && flush_q != 16'hFFFF) ? flush_q + 16'd1 : flush_q;
  end
  // counter registers
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      stall_q <= 16'd0;
      flush_q <= 16'd0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = 16'd0;
  assign flush_cnt = 16'd0;
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed and random checks of pipeline_hazard_ctrl against a behavioural model
module tb_pipeline_hazard_ctrl;
  logic CLK = 1'b0, RSTn = 1'b0;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic id_useRs1, id_useRs2, ex_valid, ex_isLoad, ex_isBranch, ex_bpr, ex_taken;
  logic mem_req, mem_ready, wb_valid, wb_probablyHalt;
  logic latchn_ifid, latchn_idex, latchn_exmem, latchn_memwb, flush_ifid, flush_idex;
  logic pc_hold, redirect, halt, mem_timeout;
  logic [15:0] stall_cnt, flush_cnt;
  int n_vec = 0, n_err = 0;
  bit m_halt, m_to;
  int m_wait, m_stall, m_flush;
  pipeline_hazard_ctrl dut (
    .CLK(CLK), .RSTn(RSTn), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_useRs1(id_useRs1), .id_useRs2(id_useRs2),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_isLoad(ex_isLoad), .ex_isBranch(ex_isBranch), .ex_bpr(ex_bpr),
    .ex_taken(ex_taken), .mem_req(mem_req), .mem_ready(mem_ready), .wb_valid(wb_valid),
    .wb_probablyHalt(wb_probablyHalt), .latchn_ifid(latchn_ifid), .latchn_idex(latchn_idex),
    .latchn_exmem(latchn_exmem), .latchn_memwb(latchn_memwb), .flush_ifid(flush_ifid), .flush_idex(flush_idex),
    .pc_hold(pc_hold), .redirect(redirect), .halt(halt), .mem_timeout(mem_timeout),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );
  always #5 CLK = ~CLK;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [9:0] ctrl_now();
    return {latchn_ifid, latchn_idex, latchn_exmem, latchn_memwb, flush_ifid, flush_idex, pc_hold, redirect, halt, mem_timeout};
  endfunction
  function automatic int cnt_exp(input int v);
`ifdef HAZARD_PERF_CNT_EN
    return v;
`else
    return 0;
`endif
  endfunction
  task automatic clear_in();
    {id_rs1, id_rs2, ex_rd} = '0;
    {id_useRs1, id_useRs2, ex_valid, ex_isLoad, ex_isBranch, ex_bpr, ex_taken} = '0;
    {mem_req, mem_ready, wb_valid, wb_probablyHalt} = '0;
  endtask
  task automatic model_reset();
    m_halt = 0; m_to = 0; m_wait = 0; m_stall = 0; m_flush = 0;
  endtask
  // entered at a negedge with inputs applied; checks, advances the model, returns at the next negedge
  task automatic step(input string tag);
    bit ms, mp, lu;
    logic [7:0] e;
    ms = mem_req && !mem_ready;
    mp = ex_valid && ex_isBranch && (ex_bpr != ex_taken);
    lu = ex_valid && ex_isLoad && ex_rd != 0 && ((id_useRs1 && id_rs1 == ex_rd) || (id_useRs2 && id_rs2 == ex_rd));
    if (m_halt || ms) e = 8'b1111_00_1_0;
    else if (mp)      e = 8'b0000_11_0_1;
    else if (lu)      e = 8'b1000_01_1_0;
    else              e = 8'b0000_00_0_0;
    #1;
    check({tag, "/ctrl"}, {22'd0, ctrl_now()}, {22'd0, e, m_halt, m_to});
    check({tag, "/stall_cnt"}, {16'd0, stall_cnt}, cnt_exp(m_stall));
    check({tag, "/flush_cnt"}, {16'd0, flush_cnt}, cnt_exp(m_flush));
    if (e[1] && !m_halt && m_stall < 65535) m_stall++;
    if (e[0] && m_flush < 65535) m_flush++;
    m_wait = (!m_halt && ms) ? m_wait + 1 : 0;
    if (m_wait >= 256) m_to = 1;
    if (wb_valid && wb_probablyHalt && !ms) m_halt = 1;
    @(negedge CLK);
  endtask
  task automatic do_reset(input string tag);
    RSTn = 1'b0;
    model_reset();
    #1;
    check({tag, "/rst_ctrl"}, {22'd0, ctrl_now()}, {22'd0, 10'b1111_11_1_0_0_0});
    check({tag, "/rst_cnt"}, {stall_cnt, flush_cnt}, 32'd0);
    @(negedge CLK);
    RSTn = 1'b1;
  endtask
  initial begin
    clear_in();
    model_reset();
    @(negedge CLK);
    do_reset("init");
    // load x5 in EX, ID reads rs2=x5
    ex_valid = 1; ex_isLoad = 1; ex_rd = 5'd5; id_useRs2 = 1; id_rs2 = 5'd5;
    step("loaduse");
    clear_in();
    step("loaduse_next");
    // load to x0 never stalls
    ex_valid = 1; ex_isLoad = 1; ex_rd = 5'd0; id_useRs1 = 1; id_rs1 = 5'd0;
    step("load_x0");
    clear_in();
    do_reset("rst2");
    // mispredict wins over a simultaneous load-use
    ex_valid = 1; ex_isBranch = 1; ex_isLoad = 1; ex_bpr = 0; ex_taken = 1; ex_rd = 5'd7; id_useRs1 = 1; id_rs1 = 5'd7;
    step("mispredict_lu");
    clear_in();
    step("mispredict_next");
    // memory wait of 3 cycles, mispredict pending in EX
    mem_req = 1; ex_valid = 1; ex_isBranch = 1; ex_bpr = 1; ex_taken = 0;
    for (int i = 0; i < 3; i++) step("memwait3");
    mem_ready = 1;
    step("memwait3_done");
    clear_in();
    step("memwait3_after");
    // 255 wait cycles stays below the limit
    mem_req = 1;
    for (int i = 0; i < 255; i++) step("wait255");
    mem_ready = 1;
    step("wait255_done");
    clear_in();
    // 256 wait cycles reaches the limit and the flag sticks
    mem_req = 1;
    for (int i = 0; i < 256; i++) step("wait256");
    mem_ready = 1;
    step("wait256_done");
    clear_in();
    step("wait256_sticky");
    // halt candidate in WB
    wb_valid = 1; wb_probablyHalt = 1;
    step("halt_req");
    clear_in();
    ex_valid = 1; ex_isBranch = 1; ex_taken = 1;
    for (int i = 0; i < 3; i++) step("halted");
    do_reset("rst_halted");
    clear_in();
    step("after_halt_rst");
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if (m_halt && $urandom_range(0, 3) == 0) begin
        do_reset("rnd_rst");
        continue;
      end
      id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3)); ex_rd = 5'($urandom_range(0, 3));
      id_useRs1 = 1'($urandom); id_useRs2 = 1'($urandom); ex_valid = ($urandom_range(0, 3) != 0);
      ex_isLoad = 1'($urandom); ex_isBranch = 1'($urandom); ex_bpr = 1'($urandom); ex_taken = 1'($urandom);
      mem_req = ($urandom_range(0, 3) == 0); mem_ready = 1'($urandom);
      wb_valid = 1'($urandom); wb_probablyHalt = ($urandom_range(0, 99) == 0);
      step("random");
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have one clock CLK and reset RSTn; reset is asynchronous and active-low.
REQ-002 SHALL have ports (name direction width meaning):
- CLK  in  1  clock, all state on rising edge
- RSTn  in  1  async active-low reset
- id_rs1, id_rs2  in  5  source registers of instruction in ID
- id_useRs1, id_useRs2  in  1  ID instruction reads rs1/rs2
- ex_valid  in  1  EX holds a real (non-flushed) instruction
- ex_rd  in  5  EX destination register
- ex_isLoad  in  1  EX instruction is a load
- ex_isBranch  in  1  EX instruction is B/J type
- ex_bpr  in  1  predicted-taken bit carried with EX instruction
- ex_taken  in  1  resolved taken in EX
- mem_req  in  1  MEM stage has an outstanding data access
- mem_ready  in  1  data memory completes access this cycle
- wb_valid, wb_probablyHalt  in  1  WB instruction valid / is halt candidate
- latchn_ifid, latchn_idex, latchn_exmem, latchn_memwb  out  1  active-low latch enables to the four pipeline registers
- flush_ifid, flush_idex  out  1  squash value written into IF/ID, ID/EX
- pc_hold  out  1  PC must not advance
- redirect  out  1  PC must load resolved target
- halt  out  1  sticky processor halted
- mem_timeout  out  1  sticky: memory wait exceeded limit
- stall_cnt, flush_cnt  out  16  performance counters

Function
REQ-003 SHALL hold state in {RUN, MEM_WAIT, HALTED}; control outputs are combinational from state and current inputs.
REQ-004 Priority per cycle SHALL be: HALTED > memory wait > mispredict > load-use > normal.
REQ-005 Normal: all latchn = 0, flushes = 0, pc_hold = 0, redirect = 0.
REQ-006 Memory wait (mem_req=1 and mem_ready=0): all four latchn = 1, pc_hold = 1, flushes = 0; state -> MEM_WAIT; return to RUN the cycle mem_ready=1.
REQ-007 In MEM_WAIT, an 8-bit wait counter SHALL increment each cycle and clear on exit; reaching 255 SHALL set mem_timeout (sticky until reset); the stall continues regardless.
REQ-008 Mispredict (ex_valid & ex_isBranch & ex_bpr != ex_taken): latchn all 0, flush_ifid = flush_idex = 1, redirect = 1, pc_hold = 0, for exactly that cycle.
REQ-009 Load-use (ex_valid & ex_isLoad & ex_rd != 0 & ((id_useRs1 & id_rs1 == ex_rd) | (id_useRs2 & id_rs2 == ex_rd))): latchn_ifid = 1, pc_hold = 1, latchn_idex = 0 with flush_idex = 1 (bubble), latchn_exmem = latchn_memwb = 0; one cycle only since the load leaves EX.
REQ-010 Mispredict and load-use together SHALL produce mispredict response only.
REQ-011 Memory wait with mispredict pending SHALL stall; the mispredict is acted on when the wait ends, since EX is held.
REQ-012 wb_valid & wb_probablyHalt with no memory wait SHALL enter HALTED next edge; halt = 1 from that edge; in HALTED all latchn = 1, pc_hold = 1, flushes = 0, redirect = 0, until reset.
REQ-013 stall_cnt SHALL increment on every cycle with pc_hold = 1 outside HALTED; flush_cnt on every mispredict cycle; both saturate at 0xFFFF.

Reset
REQ-014 RSTn low SHALL asynchronously force state RUN, wait counter 0, halt = 0, mem_timeout = 0, stall_cnt = flush_cnt = 0.
REQ-015 While RSTn low, latchn outputs SHALL be 1, flushes 1, pc_hold 1, redirect 0; normal decode resumes the first cycle after deassertion.
REQ-016 Reset asserted mid-MEM_WAIT or in HALTED SHALL abandon the state with no residual stall.

Configuration
REQ-017 Macro HAZARD_PERF_CNT_EN defined: stall_cnt/flush_cnt per REQ-013; undefined: counters not built, both outputs tied to 0, all other behaviour identical.

Verification
REQ-018 Bench SHALL cover:
- Load x5 in EX, ID uses rs2=x5 -> one cycle latchn_ifid=1, flush_idex=1, pc_hold=1; next cycle normal; stall_cnt=1.
- Load with ex_rd=0, ID uses x0 -> no stall.
- Branch ex_bpr=0, ex_taken=1, same cycle load-use match -> flush_ifid=flush_idex=1, redirect=1, pc_hold=0; flush_cnt=1, stall_cnt=0.
- mem_req=1, mem_ready low 3 cycles -> all latchn=1 for 3 cycles, RUN on 4th; with 256 wait cycles mem_timeout=1 and stays 1 after wait ends.
- wb_probablyHalt=1 -> halt=1 next edge, all latchn=1; RSTn pulse mid-HALTED -> halt=0, counters 0.
- HAZARD_PERF_CNT_EN undefined, repeat stall case -> stall_cnt=0, control outputs unchanged.
